// File: rtl/riscv_reg_file.sv
// riscv_reg_file: 32x32 integer register file, two async read ports, one sync write port, x0 hardwired to zero
module riscv_reg_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  WE3,
   input  logic [ADDR_WIDTH-1:0] A1,
   input  logic [ADDR_WIDTH-1:0] A2,
   input  logic [ADDR_WIDTH-1:0] A3,
   input  logic [DATA_WIDTH-1:0] WD3,
   output logic [DATA_WIDTH-1:0] RD1,
   output logic [DATA_WIDTH-1:0] RD2
);
   logic [DATA_WIDTH-1:0] regs [2**ADDR_WIDTH];
   // clear everything on reset; otherwise write rd on the edge, dropping writes to x0
   always_ff @(posedge clk)
      if (rst)
         for (int i = 0; i < 2**ADDR_WIDTH; i++) regs[i] <= '0;
      else if (WE3 && A3 != '0)
         regs[A3] <= WD3;
   // reads are combinational with no write-through, so a same-cycle write shows only after the edge
   always_comb begin
      RD1 = (A1 == '0) ? '0 : regs[A1];
      RD2 = (A2 == '0) ? '0 : regs[A2];
   end
endmodule

// File: tb/tb_riscv_reg_file.sv
// tb_riscv_reg_file: directed self-checking bench for riscv_reg_file
`timescale 1ns/1ps
module tb_riscv_reg_file;
   logic        clk = 0;
   logic        rst = 0;
   logic        WE3 = 0;
   logic [4:0]  A1 = 0, A2 = 0, A3 = 0;
   logic [31:0] WD3 = 0;
   logic [31:0] RD1, RD2;
   int n_checks = 0;
   int n_fail = 0;
   riscv_reg_file dut (
      .clk(clk), .rst(rst), .WE3(WE3), .A1(A1), .A2(A2), .A3(A3),
      .WD3(WD3), .RD1(RD1), .RD2(RD2)
   );
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      WE3 = 1; A3 = a; WD3 = d;
      tick();
      WE3 = 0;
   endtask
   initial begin
      // reset clear and full sweep
      rst = 1; WE3 = 1; A3 = 7; WD3 = 32'h1111_1111;
      tick();
      rst = 0; WE3 = 0;
      for (int a = 0; a < 32; a++) begin
         A1 = 5'(a); A2 = 5'(31 - a);
         #1;
         check($sformatf("reset_rd1_%0d", a), RD1, 32'h0);
         check($sformatf("reset_rd2_%0d", 31 - a), RD2, 32'h0);
      end
      // write then read
      wr(5'd1, 32'h1234_5678);
      A1 = 1; #1 check("wr1_rd1", RD1, 32'h1234_5678);
      A2 = 1; #1 check("wr1_rd2", RD2, 32'h1234_5678);
      // second register, port independence
      wr(5'd2, 32'h8765_4321);
      A1 = 1; A2 = 2; #1;
      check("indep_rd1", RD1, 32'h1234_5678);
      check("indep_rd2", RD2, 32'h8765_4321);
      A1 = 2; A2 = 2; #1;
      check("same_rd1", RD1, 32'h8765_4321);
      check("same_rd2", RD2, 32'h8765_4321);
      // x0 hardwired
      wr(5'd0, 32'hFFFF_FFFF);
      A1 = 0; A2 = 0; #1;
      check("x0_rd1", RD1, 32'h0);
      check("x0_rd2", RD2, 32'h0);
      A1 = 1; #1 check("x0_keep_r1", RD1, 32'h1234_5678);
      // write enable low
      WE3 = 0; A3 = 3; WD3 = 32'hDEAD_BEEF;
      tick();
      A1 = 3; A2 = 3; #1 check("we0_r3", RD1, 32'h0);
      // read during write: old before edge, new after
      WE3 = 1; #1;
      check("rdw_before_rd1", RD1, 32'h0);
      check("rdw_before_rd2", RD2, 32'h0);
      tick();
      WE3 = 0;
      check("rdw_after_rd1", RD1, 32'hDEAD_BEEF);
      check("rdw_after_rd2", RD2, 32'hDEAD_BEEF);
      // top register boundary
      wr(5'd31, 32'h8000_0001);
      A1 = 31; #1 check("r31", RD1, 32'h8000_0001);
      A2 = 30; #1 check("r30_untouched", RD2, 32'h0);
      // reset priority over same-edge write
      rst = 1; WE3 = 1; A3 = 4; WD3 = 32'hA5A5_A5A5;
      tick();
      rst = 0; WE3 = 0;
      for (int a = 1; a <= 4; a++) begin
         A1 = 5'(a); #1;
         check($sformatf("rstpri_r%0d", a), RD1, 32'h0);
      end
      A2 = 31; #1 check("rstpri_r31", RD2, 32'h0);
      // normal operation resumes
      wr(5'd4, 32'hA5A5_A5A5);
      A1 = 4; A2 = 1; #1;
      check("post_rst_r4", RD1, 32'hA5A5_A5A5);
      check("post_rst_r1", RD2, 32'h0);
      wr(5'd1, 32'h0F0F_0F0F);
      A2 = 1; #1 check("post_rst_r1b", RD2, 32'h0F0F_0F0F);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
